seg_disp_sched: RTL and testbench



---
 rtl/seg_pkg.sv | 41 ++++
 rtl/seg_scan.sv | 62 ++++++
 rtl/seg_disp_sched.sv | 86 ++++++++
 tb/tb_seg_disp_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display scheduler and scan logic.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam logic [7:0] SEG_0     = 8'hc0;
  localparam logic [7:0] SEG_1     = 8'hf9;
  localparam logic [7:0] SEG_2     = 8'ha4;
  localparam logic [7:0] SEG_3     = 8'hb0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hf8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hff;

  localparam logic [3:0] POS_RESET = 4'b1110;

  // Active-low common-anode code; non-BCD nibbles show blank.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed digit scan: slot counter, digit select rotation and registered decode.
// Leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_CYC = 50_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] word,
  output logic [3:0]  pos,
  output logic [7:0]  seg
);

  localparam int CW = $clog2(SCAN_CYC);

  logic [CW-1:0] cnt;
  logic [3:0]    nib;
  logic          blank;
  logic          lz1, lz2, lz3;

`ifdef SEG_LZB_EN
  assign lz3 = (word[15:12] == 4'h0);
  assign lz2 = (word[15:8]  == 8'h0);
  assign lz1 = (word[15:4]  == 12'h0);
`else
  assign lz3 = 1'b0;
  assign lz2 = 1'b0;
  assign lz1 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      pos <= POS_RESET;
    end else if (cnt == CW'(SCAN_CYC - 1)) begin
      cnt <= '0;
      pos <= {pos[0], pos[3:1]};
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    nib   = 4'hf;
    blank = 1'b1;
    case (pos)
      4'b1110: begin nib = word[3:0];   blank = 1'b0; end
      4'b1101: begin nib = word[7:4];   blank = lz1;  end
      4'b1011: begin nib = word[11:8];  blank = lz2;  end
      4'b0111: begin nib = word[15:12]; blank = lz3;  end
      default: begin nib = 4'hf;        blank = 1'b1; end
    endcase
  end

  // Decoding the current pos each cycle makes seg trail pos by exactly one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg <= SEG_BLANK;
    else        seg <= blank ? SEG_BLANK : seg_decode(nib);
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Round-robin display scheduler with minimum dwell, driving the shared 4-digit scan.
// Optional leading-zero blanking in seg_scan when SEG_LZB_EN is defined.
module seg_disp_sched
  import seg_pkg::*;
#(
  parameter int SCAN_CYC  = 50_000,
  parameter int DWELL_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        ack1,
  output logic        busy,
  output logic        owner,
  output logic [7:0]  seg,
  output logic [3:0]  pos
);

  localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

  state_t        state, state_nxt;
  logic          grant, win;
  logic [DW-1:0] dwell_cnt;
  logic [15:0]   disp;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win       = owner;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          state_nxt = GRANT;
          // On a tie the requester that was not served last wins.
          win       = (req0 && req1) ? ~owner : req1;
        end
      end
      GRANT:   state_nxt = DWELL;
      DWELL:   if (dwell_cnt == DW'(DWELL_CYC - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The grant decision is registered, so ack, owner and the payload all show in the GRANT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      owner     <= 1'b1;
      disp      <= 16'hffff;
      dwell_cnt <= '0;
    end else begin
      ack0 <= grant && !win;
      ack1 <= grant && win;
      if (grant) begin
        owner <= win;
        disp  <= win ? data1 : data0;
      end
      if (state == GRANT)      dwell_cnt <= '0;
      else if (state == DWELL) dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  assign busy = (state != IDLE);

  seg_scan #(
    .SCAN_CYC(SCAN_CYC)
  ) u_scan (
    .clk  (clk),
    .rst_n(rst_n),
    .word (disp),
    .pos  (pos),
    .seg  (seg)
  );

endmodule

// File: tb/tb_seg_disp_sched.sv
// Self-checking bench for seg_disp_sched: vector table, corner sequences and a randomized run
// against a timestamp-based reference model.
module tb_seg_disp_sched;

  localparam int SCAN  = 4;
  localparam int DWELL = 10;

`ifdef SEG_LZB_EN
  localparam logic [7:0] LZ = 8'hff;
`else
  localparam logic [7:0] LZ = 8'hc0;
`endif

  localparam logic [7:0] CODES [10] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99,
                                        8'h92, 8'h82, 8'hf8, 8'h80, 8'h90};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] data0 = '0, data1 = '0;
  logic        ack0, ack1, busy, owner;
  logic [7:0]  seg;
  logic [3:0]  pos;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_disp_sched #(
    .SCAN_CYC (SCAN),
    .DWELL_CYC(DWELL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req0 (req0),
    .data0(data0),
    .ack0 (ack0),
    .req1 (req1),
    .data1(data1),
    .ack1 (ack1),
    .busy (busy),
    .owner(owner),
    .seg  (seg),
    .pos  (pos)
  );

  typedef struct {
    logic [15:0]     data;
    logic [3:0][7:0] exp;   // exp[i] is the code shown for digit i
    string           name;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Cycles until the selected ack is seen, or -1 if it never comes within the budget.
  task automatic wait_ack(input int which, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if ((which == 1) ? ack1 : ack0) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic int digit_of_pos(input logic [3:0] p);
    case (p)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return 4;
    endcase
  endfunction

  // Scan position k cycles after reset release: one rightward rotation per SCAN cycles.
  function automatic logic [3:0] ref_pos(input int k);
    case ((k / SCAN) % 4)
      0:       return 4'b1110;
      1:       return 4'b0111;
      2:       return 4'b1011;
      default: return 4'b1101;
    endcase
  endfunction

  function automatic logic [7:0] ref_code(input logic [15:0] w, input int idx);
    int v;
    if (idx > 3) return 8'hff;
    v = (int'(w) >> (4 * idx)) & 15;
`ifdef SEG_LZB_EN
    if (idx > 0 && (int'(w) >> (4 * idx)) == 0) return 8'hff;
`endif
    if (v > 9) return 8'hff;
    return CODES[v];
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 11));
    if ($urandom_range(0, 3) == 0) w[15:8] = 8'h00;
    return w;
  endfunction

  task automatic set_vec(input int i, input logic [15:0] d, input logic [3:0][7:0] e,
                         input string nm);
    vecs[i].data = d;
    vecs[i].exp  = e;
    vecs[i].name = nm;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, m;
    int          idle_from;
    logic        m_own, pend, pend_win, e_ack0, e_ack1;
    logic [15:0] m_disp, prev_disp, pend_data;
    logic [3:0]  prev_pos, pl;
    logic [7:0]  e_seg;

    set_vec(0, 16'h1234, {8'hf9, 8'ha4, 8'hb0, 8'h99}, "v1234");
    set_vec(1, 16'h0070, {LZ,    LZ,    8'hf8, 8'hc0}, "v0070");
    set_vec(2, 16'h000A, {LZ,    LZ,    LZ,    8'hff}, "v000a");
    set_vec(3, 16'h9805, {8'h90, 8'h80, 8'hc0, 8'h92}, "v9805");
    set_vec(4, 16'h0F00, {LZ,    8'hff, 8'hc0, 8'hc0}, "v0f00");
    set_vec(5, 16'h6000, {8'h82, 8'hc0, 8'hc0, 8'hc0}, "v6000");

    // Reset state and one blank scan
    do_reset();
    check("rst_seg", seg, 8'hff);
    check("rst_pos", pos, 4'b1110);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 1'b1);
    check("rst_acks", {ack0, ack1}, 2'b00);
    for (int k = 1; k <= 4 * SCAN; k++) begin
      tick();
      check($sformatf("rst_scan_seg_%0d", k), seg, 8'hff);
      check($sformatf("rst_scan_pos_%0d", k), pos, ref_pos(k));
    end

    // Vector table: grant one payload, then watch a full scan
    for (int v = 0; v < 6; v++) begin
      do_reset();
      data0 = vecs[v].data;
      req0  = 1'b1;
      tick();
      check({vecs[v].name, "_ack0"}, ack0, 1'b1);
      req0 = 1'b0;
      pl   = pos;
      for (int i = 0; i < 4 * SCAN; i++) begin
        tick();
        n = digit_of_pos(pl);
        check($sformatf("%s_slot%0d", vecs[v].name, n), seg,
              (n > 3) ? 8'hff : vecs[v].exp[n]);
        pl = pos;
      end
      tick();
      check({vecs[v].name, "_ack_once"}, ack0, 1'b0);
    end

    // Simultaneous requests held high: grants alternate 0,1,0
    do_reset();
    data0 = 16'h1111;
    data1 = 16'h2222;
    req0  = 1'b1;
    req1  = 1'b1;
    wait_ack(0, 5, n);
    check("sim_first_ack0_lat", n, 1);
    check("sim_first_no_ack1", ack1, 1'b0);
    check("sim_owner0", owner, 1'b0);
    wait_ack(1, 30, n);
    check("sim_gap_0_to_1", n, DWELL + 2);
    check("sim_owner1", owner, 1'b1);
    wait_ack(0, 30, n);
    check("sim_gap_1_to_0", n, DWELL + 2);
    req0 = 1'b0;
    req1 = 1'b0;

    // Request arriving during dwell waits for the next idle cycle
    do_reset();
    data0 = 16'h4321;
    req0  = 1'b1;
    wait_ack(0, 5, n);
    check("dw_ack0_lat", n, 1);
    req0 = 1'b0;
    repeat (3) tick();
    data1 = 16'h0007;
    req1  = 1'b1;
    wait_ack(1, 30, m);
    check("dw_ack1_gap", (m < 0) ? -1 : m + 3, DWELL + 2);
    req1 = 1'b0;
    check("dw_busy_at_ack1", busy, 1'b1);

    // Asynchronous reset in the middle of a dwell
    do_reset();
    data0 = 16'h5678;
    req0  = 1'b1;
    wait_ack(0, 5, n);
    req0 = 1'b0;
    repeat (4) tick();
    check("mr_busy_before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 1'b0);
    check("mr_seg", seg, 8'hff);
    check("mr_pos", pos, 4'b1110);
    check("mr_owner", owner, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    data0 = 16'h9999;
    req0  = 1'b1;
    wait_ack(0, 5, n);
    check("mr_reack_lat", n, 1);
    req0 = 1'b0;

    // Randomized traffic against the timestamp model
    do_reset();
    idle_from = 0;
    m_own     = 1'b1;
    m_disp    = 16'hffff;
    prev_disp = 16'hffff;
    prev_pos  = 4'b1110;
    pend      = 1'b0;
    pend_win  = 1'b0;
    pend_data = '0;
    for (int k = 0; k < 800; k++) begin
      if (k > 0) tick();
      e_seg  = (k == 0) ? 8'hff : ref_code(prev_disp, digit_of_pos(prev_pos));
      e_ack0 = pend && !pend_win;
      e_ack1 = pend && pend_win;
      if (pend) begin
        m_own  = pend_win;
        m_disp = pend_data;
      end
      pend = 1'b0;
      check($sformatf("rnd_ack0_c%0d", k), ack0, e_ack0);
      check($sformatf("rnd_ack1_c%0d", k), ack1, e_ack1);
      check($sformatf("rnd_busy_c%0d", k), busy, (k < idle_from));
      check($sformatf("rnd_owner_c%0d", k), owner, m_own);
      check($sformatf("rnd_pos_c%0d", k), pos, ref_pos(k));
      check($sformatf("rnd_seg_c%0d", k), seg, e_seg);

      if (e_ack0) begin
        if ($urandom_range(0, 1) == 0) req0 = 1'b0;
        else data0 = rand_word();
      end
      if (e_ack1) begin
        if ($urandom_range(0, 1) == 0) req1 = 1'b0;
        else data1 = rand_word();
      end
      if (!req0 && $urandom_range(0, 5) == 0) begin
        req0  = 1'b1;
        data0 = rand_word();
      end
      if (!req1 && $urandom_range(0, 5) == 0) begin
        req1  = 1'b1;
        data1 = rand_word();
      end

      if (k >= idle_from && (req0 || req1)) begin
        pend      = 1'b1;
        pend_win  = (req0 && req1) ? !m_own : req1;
        pend_data = pend_win ? data1 : data0;
        idle_from = k + 2 + DWELL;
      end
      prev_disp = m_disp;
      prev_pos  = ref_pos(k);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
